boot_rom_arbiter: RTL

- Shares the single-ported boot ROM between NumPorts requesters, e.g. instruction fetch, data port and debug.
- Round-robin arbitration on the req/gnt channel.
- Tracks outstanding transactions in an in-order ID FIFO.
- Steers each ROM rvalid/rdata back to the requester that issued it.
- Sits between the core-side memory ports and the boot ROM slave.

---
 rtl/boot_rom_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/boot_rom_arbiter.sv
// Round-robin arbiter sharing the single-ported boot ROM among NumPorts requesters.
// An in-order ID FIFO steers every ROM response back to the port that issued it.
module boot_rom_arbiter #(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumPorts-1:0]                req_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0] addr_i,
    output logic [NumPorts-1:0]                gnt_o,
    output logic [NumPorts-1:0]                rvalid_o,
    output logic [DataWidth-1:0]               rdata_o,
    output logic                               rom_req_o,
    output logic [AddrWidth-1:0]               rom_addr_o,
    input  logic                               rom_gnt_i,
    input  logic                               rom_rvalid_i,
    input  logic [DataWidth-1:0]               rom_rdata_i,
    output logic                               err_o
);

    localparam int unsigned IdW  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef logic [IdW-1:0]  id_t;
    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    id_t  rr_ptr_q, rr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t wr_ptr_q, wr_ptr_d;
    cnt_t count_q, count_d;
    logic err_q, err_d;
    id_t  id_mem_q [MaxOutstanding];

    logic win_valid;
    id_t  win_id;
    id_t  cand;
    logic fifo_empty;
    logic fifo_full;
    logic accept;
    logic push;
    logic pop;

    function automatic id_t next_id(input id_t id);
        return (32'(id) == NumPorts - 1) ? id_t'(0) : id + id_t'(1);
    endfunction

    function automatic ptr_t next_ptr(input ptr_t p);
        return (32'(p) == MaxOutstanding - 1) ? ptr_t'(0) : p + ptr_t'(1);
    endfunction

    // First requester at or above rr_ptr, wrapping; a denied winner keeps its priority.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            cand = id_t'((32'(rr_ptr_q) + i) % NumPorts);
            if (!win_valid && req_i[cand]) begin
                win_valid = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == cnt_t'(MaxOutstanding));
    // A response in this cycle frees the head slot before the new ID lands.
    assign accept     = !fifo_full || rom_rvalid_i;
    assign rom_req_o  = accept && win_valid;
    assign push       = rom_req_o && rom_gnt_i;
    assign pop        = rom_rvalid_i && !fifo_empty;
    assign err_o      = err_q;

    always_comb begin
        gnt_o      = '0;
        rvalid_o   = '0;
        rdata_o    = '0;
        rom_addr_o = '0;
        if (win_valid) begin
            rom_addr_o = addr_i[win_id];
        end
        if (push) begin
            gnt_o[win_id] = 1'b1;
        end
        // Responses with nobody waiting are dropped so ROM garbage never reaches the bus.
        if (pop) begin
            rvalid_o[id_mem_q[rd_ptr_q]] = 1'b1;
            rdata_o                      = rom_rdata_i;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (push) begin
            rr_ptr_d = next_id(win_id);
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + cnt_t'(1);
        end else if (pop && !push) begin
            count_d = count_q - cnt_t'(1);
        end
        if (rom_rvalid_i && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // ID storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem_q[wr_ptr_q] <= win_id;
        end
    end

endmodule
